// File: rtl/semafor_pkg.sv
// Shared definitions for the parametrised traffic light controller.
// Holds the FSM state encoding, the default phase durations, the lamp
// bundle type and the helper that maps a state onto the lamp pattern.
package semafor_pkg;

    // FSM state encoding (3 bits, two codes unused).
    typedef enum logic [2:0] {
        VERDE  = 3'd0,
        GALBEN = 3'd1,
        CLR_A  = 3'd2,
        PIETON = 3'd3,
        CLR_B  = 3'd4,
        NOAPTE = 3'd5
    } state_t;

    // Default durations: clk cycles per second, seconds per phase.
    localparam int unsigned TICK_DIV_DEF    = 32'd1000000;
    localparam int unsigned WIDTH_DEF       = 32'd6;
    localparam int unsigned T_VERDE_MIN_DEF = 32'd60;
    localparam int unsigned T_GALBEN_DEF    = 32'd5;
    localparam int unsigned T_CLEAR_DEF     = 32'd2;
    localparam int unsigned T_PIETON_DEF    = 32'd30;
    localparam int unsigned T_FLASH_DEF     = 32'd5;

    // One bit per lamp driver.
    typedef struct packed {
        logic rosu;
        logic galben;
        logic verde;
        logic rosu_p;
        logic verde_p;
    } lamps_t;

    // Lamp pattern for a state. steady selects the solid pedestrian green,
    // blink drives the flashing lamps. Unknown codes fall back to all-red.
    function automatic lamps_t decode_lamps(input state_t s,
                                            input logic   steady,
                                            input logic   blink);
        lamps_t l;
        l = '0;
        case (s)
            VERDE: begin
                l.verde  = 1'b1;
                l.rosu_p = 1'b1;
            end
            GALBEN: begin
                l.galben = 1'b1;
                l.rosu_p = 1'b1;
            end
            PIETON: begin
                l.rosu    = 1'b1;
                l.verde_p = steady | blink;
            end
            NOAPTE: begin
                l.galben = blink;
            end
            default: begin
                l.rosu   = 1'b1;
                l.rosu_p = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semafor_if.sv
// Board-side bundle of the traffic light controller: push-button and
// night-mode inputs plus the lamp driver outputs and the wait lamp.
//   master : the board / stimulus side (drives buton, noapte)
//   slave  : the controller (drives the lamps)
interface semafor_if;
    logic buton;
    logic noapte;
    logic rosu;
    logic galben;
    logic verde;
    logic rosu_p;
    logic verde_p;
    logic asteapta;

    modport master (
        output buton, noapte,
        input  rosu, galben, verde, rosu_p, verde_p, asteapta
    );

    modport slave (
        input  buton, noapte,
        output rosu, galben, verde, rosu_p, verde_p, asteapta
    );
endinterface

// File: rtl/semafor_tick.sv
// One-second prescaler. Counts 0..TICK_DIV-1 and wraps; tick is high in
// the cycle the count sits at TICK_DIV-1. clr restarts the second so a
// new phase always starts on a whole-second boundary.
//   clk   : system clock
//   rst_n : synchronous reset, active high
//   clr   : restart the count at 0 on the next edge
//   tick  : one-cycle pulse once per TICK_DIV cycles
module semafor_tick #(
    parameter int unsigned TICK_DIV = 32'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned   CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 32'd1);

    logic [CW-1:0] cnt_r;

    // Prescaler counter with reset, phase-restart and wrap.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);
endmodule

// File: rtl/semafor_param.sv
// Parametrised single-intersection traffic light controller.
// Vehicle head (rosu/galben/verde), pedestrian head (rosu_p/verde_p),
// registered pedestrian request with wait lamp, flashing pedestrian green
// at the end of the crossing phase and flashing yellow night mode.
//   clk   : system clock (TICK_DIV cycles per second)
//   rst_n : synchronous reset, active high
//   bus   : buton/noapte in, lamps and asteapta out
module semafor_param
    import semafor_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
    parameter int unsigned T_GALBEN    = T_GALBEN_DEF,
    parameter int unsigned T_CLEAR     = T_CLEAR_DEF,
    parameter int unsigned T_PIETON    = T_PIETON_DEF,
    parameter int unsigned T_FLASH     = T_FLASH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    semafor_if.slave bus
);
    localparam int unsigned TMAX = 32'd1 << WIDTH;

    if (T_VERDE_MIN < 32'd1 || T_VERDE_MIN >= TMAX) begin : g_chk_verde
        $error("T_VERDE_MIN out of range for WIDTH");
    end
    if (T_GALBEN < 32'd1 || T_GALBEN >= TMAX) begin : g_chk_galben
        $error("T_GALBEN out of range for WIDTH");
    end
    if (T_CLEAR < 32'd1 || T_CLEAR >= TMAX) begin : g_chk_clear
        $error("T_CLEAR out of range for WIDTH");
    end
    if (T_PIETON < 32'd1 || T_PIETON >= TMAX) begin : g_chk_pieton
        $error("T_PIETON out of range for WIDTH");
    end
    if (T_FLASH < 32'd1 || T_FLASH >= TMAX) begin : g_chk_flash
        $error("T_FLASH out of range for WIDTH");
    end
    if (T_FLASH > T_PIETON) begin : g_chk_flash_le
        $error("T_FLASH must not exceed T_PIETON");
    end
    if (TICK_DIV < 32'd2) begin : g_chk_div
        $error("TICK_DIV must be at least 2");
    end

    localparam logic [WIDTH-1:0] FLASH_W = WIDTH'(T_FLASH);
    localparam lamps_t           LAMPS_RESET = '{rosu: 1'b1, galben: 1'b0, verde: 1'b0,
                                                 rosu_p: 1'b1, verde_p: 1'b0};

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] sec_r, sec_dec_s, sec_nxt_s;
    logic             cerere_r, cerere_nxt_s;
    logic             blink_r, blink_nxt_s;
    logic             tick_s, expired_s, change_s, flash_s;
    lamps_t           lamps_r, lamps_nxt_s;
    logic             asteapta_r;

    // Seconds loaded on entry: phase length minus one so the phase ends on
    // the tick that finds the counter at zero. Night mode is untimed.
    function automatic logic [WIDTH-1:0] t_load(input state_t s);
        logic [WIDTH-1:0] v;
        case (s)
            VERDE:   v = WIDTH'(T_VERDE_MIN - 32'd1);
            GALBEN:  v = WIDTH'(T_GALBEN - 32'd1);
            CLR_A:   v = WIDTH'(T_CLEAR - 32'd1);
            PIETON:  v = WIDTH'(T_PIETON - 32'd1);
            CLR_B:   v = WIDTH'(T_CLEAR - 32'd1);
            default: v = {WIDTH{1'b0}};
        endcase
        return v;
    endfunction

    semafor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (change_s),
        .tick  (tick_s)
    );

    assign expired_s = tick_s & (sec_r == {WIDTH{1'b0}});

    // Next-state selection; timed phases only move on expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            VERDE: begin
                if (expired_s && (cerere_r || bus.noapte)) begin
                    state_nxt_s = GALBEN;
                end else begin
                    state_nxt_s = VERDE;
                end
            end
            GALBEN: begin
                if (expired_s) begin
                    state_nxt_s = bus.noapte ? NOAPTE : CLR_A;
                end else begin
                    state_nxt_s = GALBEN;
                end
            end
            CLR_A: begin
                if (expired_s) begin
                    state_nxt_s = PIETON;
                end else begin
                    state_nxt_s = CLR_A;
                end
            end
            PIETON: begin
                if (expired_s) begin
                    state_nxt_s = CLR_B;
                end else begin
                    state_nxt_s = PIETON;
                end
            end
            CLR_B: begin
                if (expired_s) begin
                    state_nxt_s = bus.noapte ? NOAPTE : VERDE;
                end else begin
                    state_nxt_s = CLR_B;
                end
            end
            NOAPTE: begin
                if (!bus.noapte) begin
                    state_nxt_s = CLR_B;
                end else begin
                    state_nxt_s = NOAPTE;
                end
            end
            default: state_nxt_s = CLR_B;
        endcase
    end

    assign change_s = (state_nxt_s != state_r);

    // Seconds counter, blink phase, request register and lamp pattern.
    always_comb begin
        sec_dec_s = sec_r;
        if (tick_s && (sec_r != {WIDTH{1'b0}})) begin
            sec_dec_s = sec_r - WIDTH'(1);
        end else begin
            sec_dec_s = sec_r;
        end

        if (change_s) begin
            sec_nxt_s = t_load(state_nxt_s);
        end else begin
            sec_nxt_s = sec_dec_s;
        end

        // The flash test looks at the post-tick seconds value so that the
        // first flashing second of the crossing phase starts dark.
        flash_s = (state_r == NOAPTE) ||
                  ((state_r == PIETON) && (sec_dec_s < FLASH_W));

        if (change_s) begin
            blink_nxt_s = 1'b1;
        end else if (tick_s && flash_s) begin
            blink_nxt_s = ~blink_r;
        end else begin
            blink_nxt_s = blink_r;
        end

        // Entry into the crossing phase serves the request and beats a
        // coincident press; presses during the crossing are not latched.
        if (change_s && (state_nxt_s == PIETON)) begin
            cerere_nxt_s = 1'b0;
        end else if (bus.buton && (state_r != PIETON)) begin
            cerere_nxt_s = 1'b1;
        end else begin
            cerere_nxt_s = cerere_r;
        end

        lamps_nxt_s = decode_lamps(state_nxt_s, (sec_nxt_s >= FLASH_W), blink_nxt_s);
    end

    // FSM state, timers, request and registered lamp drivers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r    <= CLR_B;
            sec_r      <= WIDTH'(T_CLEAR - 32'd1);
            cerere_r   <= 1'b0;
            blink_r    <= 1'b1;
            lamps_r    <= LAMPS_RESET;
            asteapta_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sec_r      <= sec_nxt_s;
            cerere_r   <= cerere_nxt_s;
            blink_r    <= blink_nxt_s;
            lamps_r    <= lamps_nxt_s;
            asteapta_r <= cerere_nxt_s;
        end
    end

    assign bus.rosu     = lamps_r.rosu;
    assign bus.galben   = lamps_r.galben;
    assign bus.verde    = lamps_r.verde;
    assign bus.rosu_p   = lamps_r.rosu_p;
    assign bus.verde_p  = lamps_r.verde_p;
    assign bus.asteapta = asteapta_r;
endmodule

// File: tb/tb_semafor_param.sv
// Directed bench for semafor_param with a phase/elapsed-time model that
// is compared against the lamps on every cycle, plus literal checks of
// phase lengths and entry patterns.
module tb_semafor_param;
    localparam int TD = 4, TV = 3, TG = 2, TC = 1, TP = 4, TF = 2;
    localparam int S_V = 0, S_G = 1, S_CA = 2, S_P = 3, S_CB = 4, S_N = 5;
    localparam logic [5:0] ALL = 6'b111111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    semafor_if bus();

    semafor_param #(
        .TICK_DIV    (TD),
        .WIDTH       (6),
        .T_VERDE_MIN (TV),
        .T_GALBEN    (TG),
        .T_CLEAR     (TC),
        .T_PIETON    (TP),
        .T_FLASH     (TF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {rosu, galben, verde, rosu_p, verde_p, asteapta}
    wire [5:0] obs = {bus.rosu, bus.galben, bus.verde, bus.rosu_p, bus.verde_p, bus.asteapta};

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: current phase, cycles since it was entered, pending request.
    int   m_state = S_CB;
    int   m_el = 0;
    logic m_req = 1'b0;
    logic m_valid = 1'b0;

    always @(posedge clk) begin : model
        int  nx;
        bit  sec_end;
        int  secs;
        if (rst_n) begin
            m_state <= S_CB;
            m_el    <= 0;
            m_req   <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            sec_end = ((m_el + 1) % TD) == 0;
            secs    = (m_el + 1) / TD;
            nx      = m_state;
            case (m_state)
                S_V:  if (sec_end && secs >= TV && (m_req || bus.noapte)) nx = S_G;
                S_G:  if (sec_end && secs == TG) nx = bus.noapte ? S_N : S_CA;
                S_CA: if (sec_end && secs == TC) nx = S_P;
                S_P:  if (sec_end && secs == TP) nx = S_CB;
                S_CB: if (sec_end && secs == TC) nx = bus.noapte ? S_N : S_V;
                default: if (!bus.noapte) nx = S_CB;
            endcase
            if (nx == S_P && m_state != S_P) m_req <= 1'b0;
            else if (bus.buton && m_state != S_P) m_req <= 1'b1;
            m_el    <= (nx != m_state) ? 0 : m_el + 1;
            m_state <= nx;
        end
    end

    function automatic logic [5:0] model_vec();
        logic vp, gb;
        vp = (m_el < (TP - TF) * TD) ? 1'b1 : ((((m_el / TD) - (TP - TF)) % 2) == 1);
        gb = ((m_el / TD) % 2) == 0;
        case (m_state)
            S_V:     return {5'b00110, m_req};
            S_G:     return {5'b01010, m_req};
            S_P:     return {4'b1000, vp, m_req};
            S_N:     return {1'b0, gb, 3'b000, m_req};
            default: return {5'b10010, m_req};
        endcase
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) check("model", obs, model_vec());
    end

    // Count consecutive cycles (from now) where the masked lamps equal val.
    task automatic run_len(input logic [5:0] mask, input logic [5:0] val,
                           input int budget, output int n);
        n = 0;
        while (n < budget && ((obs & mask) == val)) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_match(input logic [5:0] mask, input logic [5:0] val,
                              input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && ((obs & mask) != val)) begin
            n++;
            @(negedge clk);
        end
        check(name, ((obs & mask) == val), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst_n      = 1'b1;
        bus.buton  = 1'b0;
        bus.noapte = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vec", obs, 6'b100100);
        rst_n = 1'b0;
        run_len(ALL, 6'b100100, 20, n);
        check("clrb_after_reset", n, 4);
        check("verde_entry", obs, 6'b001100);

        // Request 2 cycles into green: full cycle through the crossing.
        @(negedge clk); @(negedge clk);
        bus.buton = 1'b1;
        @(negedge clk);
        bus.buton = 1'b0;
        check("asteapta_set", obs[0], 1);
        run_len(6'b001000, 6'b001000, 40, n);
        check("verde_len", n + 3, 12);
        run_len(6'b010000, 6'b010000, 40, n);
        check("galben_len", n, 8);
        run_len(ALL, 6'b100101, 40, n);
        check("clra_len", n, 4);
        check("pieton_entry", obs, 6'b100010);
        run_len(6'b111110, 6'b100010, 40, n);
        check("vp_steady", n, 8);
        run_len(6'b111110, 6'b100000, 40, n);
        check("vp_off", n, 4);
        run_len(6'b111110, 6'b100010, 40, n);
        check("vp_on", n, 4);
        run_len(ALL, 6'b100100, 40, n);
        check("clrb_len", n, 4);

        // No request: green holds.
        run_len(ALL, 6'b001100, 30, n);
        check("verde_holds", n, 30);

        // Late request at green cycle 30: yellow on the next second boundary.
        bus.buton = 1'b1;
        @(negedge clk);
        bus.buton = 1'b0;
        run_len(6'b001000, 6'b001000, 10, n);
        check("late_req_latency", n + 1, 2);

        // Presses during the crossing are ignored.
        wait_match(6'b000010, 6'b000010, 60, "reach_pieton_1");
        repeat (3) @(negedge clk);
        bus.buton = 1'b1;
        @(negedge clk);
        bus.buton = 1'b0;
        check("pieton_btn_ignored", obs[0], 0);
        wait_match(6'b001000, 6'b001000, 60, "back_to_verde");
        run_len(ALL, 6'b001100, 20, n);
        check("no_pending_after_pieton", n, 20);

        // Night mode after min green has elapsed.
        bus.noapte = 1'b1;
        run_len(6'b001000, 6'b001000, 10, n);
        check("noapte_verde_exit", n, 4);
        run_len(ALL, 6'b010100, 20, n);
        check("galben_to_night", n, 8);
        run_len(ALL, 6'b010000, 20, n);
        check("night_on_1", n, 4);
        run_len(ALL, 6'b000000, 20, n);
        check("night_off_1", n, 4);
        run_len(ALL, 6'b010000, 20, n);
        check("night_on_2", n, 4);
        bus.noapte = 1'b0;
        @(negedge clk);
        check("night_exit_clrb", obs, 6'b100100);
        run_len(ALL, 6'b100100, 20, n);
        check("clrb_after_night", n, 4);
        check("verde_after_night", obs, 6'b001100);

        // Reset in the middle of the crossing phase.
        bus.buton = 1'b1;
        @(negedge clk);
        bus.buton = 1'b0;
        wait_match(6'b000010, 6'b000010, 80, "reach_pieton_2");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_mid_pieton", obs, 6'b100100);
        rst_n = 1'b0;
        run_len(ALL, 6'b100100, 20, n);
        check("clrb_after_mid_reset", n, 4);
        check("verde_after_mid_reset", obs, 6'b001100);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/semafor_param.md
Name: semafor_param

Overview:
- Parametrised successor of the single-intersection traffic light controller: one vehicle head (rosu/galben/verde) plus one pedestrian head (rosu_p/verde_p).
- Adds an internal 1 s tick prescaler, configurable phase durations and all-red clearance intervals.
- Pedestrian requests are registered, with a wait indicator. The pedestrian green flashes during its final seconds. A night mode flashes the vehicle yellow.
- Sits directly between the board push-button/mode switch and the lamp drivers.

Parameters:
- TICK_DIV, 1000000: clk cycles per 1 s tick (1 MHz clock).
- WIDTH, 6: width of the phase seconds counter.
- T_VERDE_MIN, 60: minimum vehicle green, seconds.
- T_GALBEN, 5: vehicle yellow, seconds.
- T_CLEAR, 2: all-red clearance, seconds.
- T_PIETON, 30: pedestrian green, seconds.
- T_FLASH, 5: final seconds of pedestrian green during which verde_p flashes.

Ports:
- clk  input  1  system clock, 1 MHz.
- rst_n  input  1  reset, synchronous, active-high (rst_n=1 resets on the clk edge).
- buton  input  1  pedestrian push-button, level, already synchronised.
- noapte  input  1  night mode request, level.
- rosu  output  1  vehicle red.
- galben  output  1  vehicle yellow.
- verde  output  1  vehicle green.
- rosu_p  output  1  pedestrian red.
- verde_p  output  1  pedestrian green.
- asteapta  output  1  pedestrian request pending ("wait" lamp).

Behaviour:
- Elaboration checks:
  - every T_* must satisfy 1 <= T < 2^WIDTH;
  - T_FLASH must be <= T_PIETON;
  - TICK_DIV must be >= 2.
- States:
  - VERDE: vehicle green.
  - GALBEN: vehicle yellow.
  - CLR_A: all-red clearance after yellow.
  - PIETON: pedestrian green.
  - CLR_B: all-red clearance after the pedestrian phase.
  - NOAPTE: night mode.
- Phase timer:
  - On every state change: sec counter loads T_state-1, prescaler clears to 0, blink phase sets to 1.
  - Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle it equals TICK_DIV-1.
  - On tick, sec counter decrements, saturating at 0.
  - expired = tick & (sec==0).
  - Timed state lasts exactly T*TICK_DIV cycles.
- Transitions (evaluated only on expired, except NOAPTE):
  - VERDE -> GALBEN when expired & (cerere | noapte). Otherwise stay: counter sits at 0, and the next tick with a request/noapte exits.
  - GALBEN -> NOAPTE if noapte, else CLR_A.
  - CLR_A -> PIETON.
  - PIETON -> CLR_B. Always completes, noapte ignored.
  - CLR_B -> NOAPTE if noapte, else VERDE.
  - NOAPTE -> CLR_B in the first cycle noapte=0 (CLR_B timed T_CLEAR).
- Request register cerere:
  - set on any cycle with buton=1 and state != PIETON;
  - cleared on the cycle of entry into PIETON;
  - buton during PIETON is ignored;
  - set has priority over hold, and clear has priority over set.
  - asteapta = cerere.
- Blink phase:
  - toggles on each tick while in NOAPTE, or in PIETON with sec < T_FLASH;
  - otherwise holds.
- Outputs (Moore, decoded from registered state/blink):
  - VERDE: verde=1, rosu_p=1.
  - GALBEN: galben=1, rosu_p=1.
  - CLR_A/CLR_B: rosu=1, rosu_p=1.
  - PIETON: rosu=1; verde_p=1 when sec >= T_FLASH, else verde_p=blink.
  - NOAPTE: galben=blink; all other lamps 0.
  - At most one vehicle lamp is active at any time. rosu_p and verde_p are never both 1.
- Reset (rst_n=1):
  - state=CLR_B, sec=T_CLEAR-1, prescaler=0, cerere=0, blink=1.
  - Outputs after reset: rosu=1, rosu_p=1, all others 0, asteapta=0.
  - Reset mid-phase abandons the phase immediately on the same edge.
- Simultaneous events:
  - buton in the cycle PIETON is entered: request is dropped (clear wins).
  - noapte and cerere both set at VERDE expiry: GALBEN -> NOAPTE; cerere stays pending and is served after night mode ends.

Decomposition:
- Shared package semafor_pkg: state encoding localparams (VERDE, GALBEN, CLR_A, PIETON, CLR_B, NOAPTE, 3 bits) and default duration constants.
- One sub-module semafor_tick: prescaler with a clear input and tick output, parameter TICK_DIV.
- FSM, sec counter, request and blink logic live in semafor_param.

Test Plan (TICK_DIV=4, T_VERDE_MIN=3, T_GALBEN=2, T_CLEAR=1, T_PIETON=4, T_FLASH=2):
- Reset held 3 cycles, then released, no buton:
  - rosu=rosu_p=1 for 4 cycles;
  - then verde=1 indefinitely, asteapta=0.
- buton pulse 1 cycle at 2 cycles into VERDE:
  - asteapta=1;
  - VERDE lasts 12 cycles, then GALBEN 8, CLR_A 4;
  - PIETON 16 with verde_p steady for 8 cycles, then 0 for 4, 1 for 4;
  - asteapta=0 from PIETON entry; then CLR_B 4, then VERDE.
- buton pulsed during PIETON only: no pending request afterwards; VERDE holds past 12 cycles.
- buton arriving after min green expired (VERDE at 20 cycles): GALBEN entered at the next tick boundary, within 4 cycles.
- noapte=1 during VERDE, no request:
  - after min green, GALBEN 8 cycles, then NOAPTE;
  - galben toggles every 4 cycles, starting at 1, all other lamps 0.
  - noapte=0: next cycle CLR_B (rosu=rosu_p=1) for 4 cycles, then VERDE.
- rst_n=1 asserted mid-PIETON: the next edge gives rosu=rosu_p=1, verde_p=0, asteapta=0, and the state sequence restarts as in the first scenario.
